// File: rtl/cdec_bus_ctrl.sv
// Core-to-memory bus controller: turns a core access code into a
// SETUP / STROBE / DONE memory cycle with programmable wait states and
// external ready, and keeps saturating read/write/error statistics.
//
// state  | meaning
// IDLE   | waiting for a read or write request
// SETUP  | address/data driven, strobes still high
// STROBE | strobe low; wait counter runs, then mem_ready is honoured
// DONE   | access complete; read data valid, counters bumped
module cdec_bus_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        mmrw,
  input  logic [ADDR_W-1:0] adrs,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_adrs,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd_N,
  output logic              mem_wr_N,
  output logic              mem_dboe,
  input  logic              mem_ready,
  input  logic              cnt_clr,
  input  logic [1:0]        dbg_sel,
  output logic [CNT_W-1:0]  dbg_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LOAD = WAIT_CYC[3:0];

  state_t           state, state_nxt;
  logic [3:0]       wait_cnt, wait_nxt;
  logic             op_wr;
  logic [CNT_W-1:0] rd_cnt, wr_cnt, err_cnt;
  logic             req_rd, req_wr, req_bad, start, strobe_end;
  logic [5:0]       dbg_word;

  assign req_rd     = (mmrw == 2'b10);
  assign req_wr     = (mmrw == 2'b01);
  assign req_bad    = (mmrw == 2'b11);
  assign start      = (state == IDLE) && (req_rd || req_wr);
  assign strobe_end = (state == STROBE) && (wait_cnt == 4'd0) && mem_ready;

  // State and wait counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next-state logic and strobe/handshake outputs decoded from the state
  // register, so an async reset drops the strobes without a clock edge
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    mem_rd_N    = 1'b1;
    mem_wr_N    = 1'b1;
    mem_dboe    = 1'b0;
    rdata_valid = 1'b0;
    stall       = 1'b0;
    case (state)
      IDLE: begin
        stall = !reset && (req_rd || req_wr);
        if (req_rd || req_wr) begin
          state_nxt = SETUP;
          wait_nxt  = WAIT_LOAD;
        end
      end
      SETUP: begin
        stall     = 1'b1;
        mem_dboe  = op_wr;
        state_nxt = STROBE;
      end
      STROBE: begin
        stall    = 1'b1;
        mem_dboe = op_wr;
        mem_rd_N = op_wr;
        mem_wr_N = !op_wr;
        if (wait_cnt != 4'd0) wait_nxt = wait_cnt - 4'd1;
        else if (mem_ready)   state_nxt = DONE;
      end
      DONE: begin
        mem_dboe    = op_wr;
        rdata_valid = !op_wr;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches load only when an access is accepted from IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_wr     <= 1'b0;
      mem_adrs  <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      op_wr    <= req_wr;
      mem_adrs <= adrs;
      if (req_wr) mem_wdata <= wdata;
    end
  end

  // Read data captured on the edge that leaves STROBE, held until next read
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    rdata <= '0;
    else if (strobe_end && !op_wr) rdata <= mem_data_in;
  end

  // Saturating statistics; a clear in the same cycle wins over an increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else if (cnt_clr) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (state == DONE && !op_wr && rd_cnt != '1) rd_cnt <= rd_cnt + CNT_W'(1);
      if (state == DONE && op_wr && wr_cnt != '1)  wr_cnt <= wr_cnt + CNT_W'(1);
      if (state == IDLE && req_bad && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign dbg_word = {state, wait_cnt};

  // Debug readout mux
  always_comb begin
    dbg_data = '0;
    case (dbg_sel)
      2'd0:    dbg_data = rd_cnt;
      2'd1:    dbg_data = wr_cnt;
      2'd2:    dbg_data = err_cnt;
      default: dbg_data = CNT_W'(dbg_word);
    endcase
  end

endmodule

// File: tb/tb_cdec_bus_ctrl.sv
// Bench for cdec_bus_ctrl: instance a (WAIT_CYC=0, CNT_W=16) and
// instance b (WAIT_CYC=2, CNT_W=4). Read data goes through a scoreboard
// popped by per-instance monitors on rdata_valid.
module tb_cdec_bus_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];

  logic [1:0]  a_mmrw, b_mmrw, a_dbg_sel, b_dbg_sel;
  logic [7:0]  a_adrs, b_adrs, a_wdata, b_wdata, a_mem_data_in, b_mem_data_in;
  logic [7:0]  a_rdata, b_rdata, a_mem_adrs, b_mem_adrs, a_mem_wdata, b_mem_wdata;
  logic        a_rdata_valid, b_rdata_valid, a_stall, b_stall;
  logic        a_mem_rd_N, b_mem_rd_N, a_mem_wr_N, b_mem_wr_N;
  logic        a_mem_dboe, b_mem_dboe, a_mem_ready, b_mem_ready;
  logic        a_cnt_clr, b_cnt_clr;
  logic [15:0] a_dbg_data;
  logic [3:0]  b_dbg_data;

  always #5 clock = ~clock;

  cdec_bus_ctrl #(.DATA_W(8), .ADDR_W(8), .WAIT_CYC(0), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .mmrw(a_mmrw), .adrs(a_adrs), .wdata(a_wdata),
    .rdata(a_rdata), .rdata_valid(a_rdata_valid), .stall(a_stall),
    .mem_adrs(a_mem_adrs), .mem_wdata(a_mem_wdata), .mem_data_in(a_mem_data_in),
    .mem_rd_N(a_mem_rd_N), .mem_wr_N(a_mem_wr_N), .mem_dboe(a_mem_dboe),
    .mem_ready(a_mem_ready), .cnt_clr(a_cnt_clr), .dbg_sel(a_dbg_sel),
    .dbg_data(a_dbg_data));

  cdec_bus_ctrl #(.DATA_W(8), .ADDR_W(8), .WAIT_CYC(2), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .mmrw(b_mmrw), .adrs(b_adrs), .wdata(b_wdata),
    .rdata(b_rdata), .rdata_valid(b_rdata_valid), .stall(b_stall),
    .mem_adrs(b_mem_adrs), .mem_wdata(b_mem_wdata), .mem_data_in(b_mem_data_in),
    .mem_rd_N(b_mem_rd_N), .mem_wr_N(b_mem_wr_N), .mem_dboe(b_mem_dboe),
    .mem_ready(b_mem_ready), .cnt_clr(b_cnt_clr), .dbg_sel(b_dbg_sel),
    .dbg_data(b_dbg_data));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  // Scoreboard monitors: pop an expected read value on every rdata_valid
  always @(negedge clock) begin
    if (a_rdata_valid === 1'b1) begin
      if (q_a.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
      else check("a_rdata", a_rdata, q_a.pop_front());
    end
    if (b_rdata_valid === 1'b1) begin
      if (q_b.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
      else check("b_rdata", b_rdata, q_b.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  wr_low, oe_hi;
    logic got;
    reset = 1'b1;
    a_mmrw = 2'b10; b_mmrw = 2'b01;
    a_adrs = '0; b_adrs = '0; a_wdata = '0; b_wdata = '0;
    a_mem_data_in = '0; b_mem_data_in = '0;
    a_mem_ready = 1'b1; b_mem_ready = 1'b1;
    a_cnt_clr = 1'b0; b_cnt_clr = 1'b0;
    a_dbg_sel = 2'd0; b_dbg_sel = 2'd0;

    // reset state, with requests presented to exercise stall gating
    repeat (2) @(posedge clock);
    smp();
    check("rst_a_stall", a_stall, 0);
    check("rst_a_rd_n", a_mem_rd_N, 1);
    check("rst_a_wr_n", a_mem_wr_N, 1);
    check("rst_a_dboe", a_mem_dboe, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_a_valid", a_rdata_valid, 0);
    check("rst_a_adrs", a_mem_adrs, 0);
    check("rst_a_rdcnt", a_dbg_data, 0);
    check("rst_b_stall", b_stall, 0);
    check("rst_b_wr_n", b_mem_wr_N, 1);
    check("rst_b_dboe", b_mem_dboe, 0);
    a_mmrw = 2'b00; b_mmrw = 2'b00;
    reset = 1'b0;
    nxt();

    // read, no wait states; request held through DONE must not restart
    a_adrs = 8'h3C; a_mem_data_in = 8'hA5; a_mmrw = 2'b10;
    q_a.push_back(8'hA5);
    for (int c = 0; c < 3; c++) begin
      smp();
      check("a1_stall", a_stall, 1);
      check("a1_rd_n", a_mem_rd_N, (c == 2) ? 32'd0 : 32'd1);
      check("a1_dboe", a_mem_dboe, 0);
      nxt();
    end
    smp();
    check("a1_done_stall", a_stall, 0);
    check("a1_adrs", a_mem_adrs, 8'h3C);
    nxt();
    a_mmrw = 2'b00; a_dbg_sel = 2'd3;
    #1 check("a1_no_restart", a_dbg_data, 0);
    a_dbg_sel = 2'd0;
    #1 check("a1_rd_cnt", a_dbg_data, 1);

    // read with mem_ready low for the first 4 strobe cycles
    nxt();
    a_adrs = 8'h81; a_mem_data_in = 8'h00; a_mem_ready = 1'b0; a_mmrw = 2'b10;
    q_a.push_back(8'h77);
    nxt(); nxt();
    for (int i = 0; i < 5; i++) begin
      smp();
      check("a2_rd_n", a_mem_rd_N, 0);
      check("a2_stall", a_stall, 1);
      if (i == 4) begin
        a_mem_ready = 1'b1;
        a_mem_data_in = 8'h77;
      end
      nxt();
    end
    smp();
    check("a2_done_stall", a_stall, 0);
    check("a2_done_valid", a_rdata_valid, 1);
    a_mmrw = 2'b00; a_mem_data_in = 8'h11;
    nxt(); nxt(); smp();
    check("a2_rdata_hold", a_rdata, 8'h77);
    check("a2_valid_low", a_rdata_valid, 0);

    // illegal code: err_cnt 1,2,3 then cleared by cnt_clr
    nxt();
    a_mmrw = 2'b11; a_dbg_sel = 2'd2;
    for (int k = 0; k < 4; k++) begin
      smp();
      check("a3_stall", a_stall, 0);
      check("a3_rd_n", a_mem_rd_N, 1);
      check("a3_wr_n", a_mem_wr_N, 1);
      check("a3_err_cnt", a_dbg_data, k);
      if (k == 3) a_cnt_clr = 1'b1;
      nxt();
    end
    smp();
    check("a3_err_clr", a_dbg_data, 0);
    a_dbg_sel = 2'd0;
    #1 check("a3_rd_clr", a_dbg_data, 0);
    a_mmrw = 2'b00; a_cnt_clr = 1'b0;

    // write with two wait states
    nxt();
    b_adrs = 8'h10; b_wdata = 8'h5A; b_mmrw = 2'b01;
    wr_low = 0; oe_hi = 0;
    for (int c = 0; c < 7; c++) begin
      smp();
      if (!b_mem_wr_N) wr_low++;
      if (b_mem_dboe) begin
        oe_hi++;
        check("b_wdata", b_mem_wdata, 8'h5A);
      end
      if (c == 5) b_mmrw = 2'b00;
      nxt();
    end
    check("b_wr_low_cycles", wr_low, 3);
    check("b_dboe_cycles", oe_hi, 5);
    check("b_adrs", b_mem_adrs, 8'h10);
    b_dbg_sel = 2'd1;
    #1 check("b_wr_cnt", b_dbg_data, 1);

    // 16 back-to-back reads saturate a 4-bit rd_cnt
    b_dbg_sel = 2'd0;
    for (int i = 0; i < 16; i++) begin
      b_mem_data_in = 8'(8'h40 + i);
      b_mmrw = 2'b10;
      q_b.push_back(b_mem_data_in);
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        smp();
        if (b_rdata_valid) got = 1'b1;
        nxt();
      end
      check("b_read_timeout", got, 1);
    end
    b_mmrw = 2'b00;
    nxt(); smp();
    check("b_rd_sat", b_dbg_data, 4'hF);

    // reset pulsed during a write strobe, then a clean write
    nxt();
    a_adrs = 8'h22; a_wdata = 8'h3E; a_mmrw = 2'b01;
    nxt(); nxt(); smp();
    check("a4_wr_n_strobe", a_mem_wr_N, 0);
    check("a4_dboe_strobe", a_mem_dboe, 1);
    #2 reset = 1'b1;
    #1;
    check("a4_wr_n_rst", a_mem_wr_N, 1);
    check("a4_dboe_rst", a_mem_dboe, 0);
    check("a4_stall_rst", a_stall, 0);
    check("a4_wdata_rst", a_mem_wdata, 0);
    a_mmrw = 2'b00;
    @(posedge clock);
    smp();
    reset = 1'b0;
    a_dbg_sel = 2'd1;
    #1 check("a4_wr_cnt_abort", a_dbg_data, 0);
    nxt();
    a_adrs = 8'h23; a_wdata = 8'h9C; a_mmrw = 2'b01;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      smp();
      if (a_mem_dboe && !a_stall) got = 1'b1;
      else nxt();
    end
    check("a4_done_seen", got, 1);
    check("a4_wdata", a_mem_wdata, 8'h9C);
    a_mmrw = 2'b00;
    nxt();
    check("a4_wr_cnt", a_dbg_data, 1);

    nxt(); nxt();
    check("sb_drain_a", q_a.size(), 0);
    check("sb_drain_b", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
